// File: rtl/thunderbolt_pkg.sv
// Shared constants for the Thunderbolt time path: register offsets,
// STATUS/CTRL bit positions and the packed time layout used by the parser.
package thunderbolt_pkg;

  localparam int TIME_W = 56;

  // Byte position of each field inside the packed time, counted from the LSB.
  localparam int FLD_SEC    = 0;
  localparam int FLD_MIN    = 1;
  localparam int FLD_HOUR   = 2;
  localparam int FLD_DAY    = 3;
  localparam int FLD_MONTH  = 4;
  localparam int FLD_YEAR_L = 5;
  localparam int FLD_YEAR_H = 6;

  localparam logic [3:0] OFS_YEAR_L = 4'd0;
  localparam logic [3:0] OFS_YEAR_H = 4'd1;
  localparam logic [3:0] OFS_MONTH  = 4'd2;
  localparam logic [3:0] OFS_DAY    = 4'd3;
  localparam logic [3:0] OFS_HOUR   = 4'd4;
  localparam logic [3:0] OFS_MIN    = 4'd5;
  localparam logic [3:0] OFS_SEC    = 4'd6;
  localparam logic [3:0] OFS_STATUS = 4'd7;
  localparam logic [3:0] OFS_CTRL   = 4'd8;

  localparam int ST_VALID = 0;
  localparam int ST_STALE = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_CNT   = 3;

  localparam int CT_IRQ_EN = 0;
  localparam int CT_FREEZE = 1;

  function automatic logic [7:0] time_byte(
    input logic [TIME_W-1:0] t,
    input logic [3:0]        ofs
  );
    logic [7:0] b;
    b = '0;
    case (ofs)
      OFS_YEAR_L: b = t[FLD_YEAR_L*8 +: 8];
      OFS_YEAR_H: b = t[FLD_YEAR_H*8 +: 8];
      OFS_MONTH:  b = t[FLD_MONTH*8 +: 8];
      OFS_DAY:    b = t[FLD_DAY*8 +: 8];
      OFS_HOUR:   b = t[FLD_HOUR*8 +: 8];
      OFS_MIN:    b = t[FLD_MIN*8 +: 8];
      OFS_SEC:    b = t[FLD_SEC*8 +: 8];
      default:    b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/thunderbolt_time_regbank_stale.sv
// pps_stale_counter: saturating count of PPS ticks since the last time update.
// Ports: i_clk, i_rst (sync, high), i_pps tick, i_clr restart, o_stale at limit.
module pps_stale_counter
  #(parameter int STALE_PPS = 3)
  (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pps,
  input  logic i_clr,
  output logic o_stale
);

  localparam int CW = $clog2(STALE_PPS + 1);

  logic [CW-1:0] r_cnt;

  // Clear has priority so a PPS coinciding with an update leaves count 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_pps && (r_cnt != CW'(STALE_PPS))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_stale = (r_cnt >= CW'(STALE_PPS));

endmodule

// File: rtl/thunderbolt_time_regbank.sv
// Host register bank for Thunderbolt GPS time: live/snapshot copies, status, ctrl, IRQ.
// Ports: host bus (i_wr,i_rd,i_addr,i_data,o_data,o_rd_valid,o_wr_err), parser (i_time_stb,i_time), i_pps, o_irq.
module thunderbolt_time_regbank
  import thunderbolt_pkg::*;
  #(
  parameter int                ADDR_W    = 7,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(7),
  parameter int                STALE_PPS = 3,
  parameter logic [7:0]        ERR_CODE  = 8'hCC
  )
  (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr,
  input  logic              i_rd,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_data,
  output logic [7:0]        o_data,
  output logic              o_rd_valid,
  output logic              o_wr_err,
  input  logic              i_time_stb,
  input  logic [TIME_W-1:0] i_time,
  input  logic              i_pps,
  output logic              o_irq
);

  logic [TIME_W-1:0] r_live;
  logic [TIME_W-1:0] r_snap;
  logic              r_lock;
  logic              r_valid;
  logic              r_ovf;
  logic              r_pend;
  logic [4:0]        r_cnt;
  logic [1:0]        r_ctrl;
  logic [7:0]        r_data;
  logic              r_rd_valid;
  logic              r_wr_err;
  logic              r_irq;

  logic [ADDR_W-1:0] w_ofs;
  logic [3:0]        w_idx;
  logic              w_hit;
  logic              w_rd_ok;
  logic              w_stb_ok;
  logic              w_rd_lock;
  logic              w_rd_sec;
  logic              w_rd_st;
  logic              w_wr_st;
  logic              w_wr_ctrl;
  logic              w_cnt_stale;
  logic              w_stale;
  logic              w_pend_nxt;
  logic [1:0]        w_ctrl_nxt;
  logic              w_ovf_nxt;
  logic [TIME_W-1:0] w_src;
  logic [7:0]        w_rdata;
  logic              w_unused;

  assign w_ofs     = i_addr - BASE_ADDR;
  assign w_idx     = w_ofs[3:0];
  assign w_hit     = (i_addr >= BASE_ADDR) && (w_ofs <= ADDR_W'(OFS_CTRL));
  assign w_rd_ok   = i_rd && !i_wr;
  assign w_stb_ok  = i_time_stb && !r_ctrl[CT_FREEZE];
  assign w_rd_lock = w_rd_ok && w_hit && (w_idx == OFS_YEAR_L);
  assign w_rd_sec  = w_rd_ok && w_hit && (w_idx == OFS_SEC);
  assign w_rd_st   = w_rd_ok && w_hit && (w_idx == OFS_STATUS);
  assign w_wr_st   = i_wr && w_hit && (w_idx == OFS_STATUS);
  assign w_wr_ctrl = i_wr && w_hit && (w_idx == OFS_CTRL);
  assign w_stale   = w_cnt_stale && r_valid;
  assign w_unused  = ^i_data[7:3];

  pps_stale_counter #(.STALE_PPS(STALE_PPS)) u_stale (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_pps  (i_pps),
    .i_clr  (w_stb_ok),
    .o_stale(w_cnt_stale)
  );

  always_comb begin
    w_pend_nxt = r_pend;
    if (w_stb_ok) w_pend_nxt = 1'b1;
    else if (w_rd_st) w_pend_nxt = 1'b0;

    w_ctrl_nxt = w_wr_ctrl ? i_data[1:0] : r_ctrl;

    // A strobe racing an open (or opening) snapshot wins over a W1C.
    w_ovf_nxt = r_ovf;
    if (w_stb_ok && (r_lock || w_rd_lock)) w_ovf_nxt = 1'b1;
    else if (w_wr_st && i_data[ST_OVF]) w_ovf_nxt = 1'b0;

    // Offset 0 always reads live: it is the byte that opens a new snapshot.
    w_src = (r_lock && (w_idx != OFS_YEAR_L)) ? r_snap : r_live;

    w_rdata = '0;
    unique case (1'b1)
      !w_hit:                    w_rdata = '0;
      w_hit && w_idx <= OFS_SEC: w_rdata = time_byte(w_src, w_idx);
      w_hit && w_idx == OFS_STATUS:
        w_rdata = {r_cnt, r_ovf, w_stale, r_valid};
      w_hit && w_idx == OFS_CTRL:
        w_rdata = {6'b0, r_ctrl};
      default:                   w_rdata = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_live     <= '0;
      r_snap     <= '0;
      r_lock     <= 1'b0;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
      r_pend     <= 1'b0;
      r_cnt      <= '0;
      r_ctrl     <= '0;
      r_data     <= '0;
      r_rd_valid <= 1'b0;
      r_wr_err   <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if (w_stb_ok) begin
        r_live  <= i_time;
        r_valid <= 1'b1;
        r_cnt   <= r_cnt + 5'd1;
      end
      if (w_rd_lock) begin
        r_snap <= r_live;
        r_lock <= 1'b1;
      end else if (w_rd_sec) begin
        r_lock <= 1'b0;
      end
      r_ovf      <= w_ovf_nxt;
      r_pend     <= w_pend_nxt;
      r_ctrl     <= w_ctrl_nxt;
      r_irq      <= w_ctrl_nxt[CT_IRQ_EN] && w_pend_nxt;
      r_rd_valid <= w_rd_ok;
      r_wr_err   <= i_wr && !(w_hit &&
                    ((w_idx == OFS_STATUS) || (w_idx == OFS_CTRL)));
      if (i_wr && i_rd) r_data <= ERR_CODE;
      else if (w_rd_ok) r_data <= w_rdata;
    end
  end

  assign o_data     = r_data;
  assign o_rd_valid = r_rd_valid;
  assign o_wr_err   = r_wr_err;
  assign o_irq      = r_irq;

endmodule
